tog_hs_rx: RTL

Receiving end of the team's two-phase toggle handshake: a sender presents a data word and flips a toggle-request line (T-flip-flop style), and this block synchronises the toggle, captures the word into a small show-ahead FIFO and answers by flipping its own toggle-acknowledge line. Captured words leave on a valid/ready stream. It sits at the boundary where toggle-signalled transfers, possibly from another clock domain, enter the local pipeline.

---
 rtl/tog_hs_rx.sv | 86 ++++++++
 1 files changed

// File: rtl/tog_hs_rx.sv
// tog_hs_rx
//   Receive side of a two-phase toggle handshake. The request toggle is
//   synchronised. Each change of the synchronised toggle captures req_data into a
//   show-ahead FIFO and flips ack_tog. Stored words leave on a valid/ready
//   stream. When the FIFO is full the acknowledge is withheld, which stalls
//   the sender. No word is ever dropped.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_tog    request toggle (may be asynchronous to clk)
//   req_data   word from sender, stable while a request is outstanding
//   ack_tog    acknowledge toggle, flips once per captured word
//   out_valid  FIFO non-empty
//   out_ready  downstream accepts head word
//   out_data   head word, 0 while empty
//   level      words stored, 0..DEPTH
//   rx_count   words captured since reset, mod 2^16
module tog_hs_rx #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_tog,
    input  logic [WIDTH-1:0]         req_data,
    output logic                     ack_tog,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              rx_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   req_s, pending, push, pop;

    assign req_s   = sync_q[SYNC_STAGES-1];
    // ack_tog holds the last toggle value already served. Any difference
    // from req_s is therefore a new word that has not yet been taken.
    assign pending = req_s != ack_tog;
    assign pop     = out_valid && out_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot in time.
    assign push    = pending && ((level != FULL) || pop);

    assign out_valid = level != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            ack_tog  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rx_count <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tog};
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                ack_tog  <= ~ack_tog;
                rx_count <= rx_count + 16'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset. out_data masks the stale contents while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= req_data;
    end

endmodule
